// File: rtl/median_filter_3x3.sv
// Three-stage pipelined 3x3 median filter fed by a line-buffer window generator.
// Define BORDER_ZERO_EN to force border outputs to 0 instead of passing the centre tap through.
module median_filter_3x3 #(
  parameter int DW    = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DW-1:0]            w1_1,
  input  logic [DW-1:0]            w1_2,
  input  logic [DW-1:0]            w1_3,
  input  logic [DW-1:0]            w2_1,
  input  logic [DW-1:0]            w2_2,
  input  logic [DW-1:0]            w2_3,
  input  logic [DW-1:0]            w3_1,
  input  logic [DW-1:0]            w3_2,
  input  logic [DW-1:0]            w3_3,
  output logic [DW-1:0]            dout,
  output logic                     dout_valid,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic                     border,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = $clog2(IMG_W + 1);

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  state_t          state, state_next;
  logic [WW-1:0]   warm_cnt;
  logic [CW-1:0]   cen_col;
  logic [RW-1:0]   cen_row;
  logic            warm_done;
  logic            centre;

  assign warm_done = (warm_cnt == WW'(IMG_W));

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    centre     = 1'b0;
    case (state)
      WARMUP: begin
        if (in_valid && warm_done) begin
          state_next = RUN;
          centre     = 1'b1;
        end
      end
      RUN: centre = in_valid;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WARMUP;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
      cen_col  <= '0;
      cen_row  <= '0;
    end else begin
      if (state == WARMUP && in_valid && !warm_done) warm_cnt <= warm_cnt + 1'b1;
      if (centre) begin
        if (cen_col == CW'(IMG_W - 1)) begin
          cen_col <= '0;
          cen_row <= (cen_row == RW'(IMG_H - 1)) ? '0 : cen_row + 1'b1;
        end else begin
          cen_col <= cen_col + 1'b1;
        end
      end
    end
  end

  logic [DW-1:0] tap [3][3];

  always_comb begin
    tap[0][0] = w1_1; tap[0][1] = w1_2; tap[0][2] = w1_3;
    tap[1][0] = w2_1; tap[1][1] = w2_2; tap[1][2] = w2_3;
    tap[2][0] = w3_1; tap[2][1] = w3_2; tap[2][2] = w3_3;
  end

  logic [DW-1:0] s1_lo [3];
  logic [DW-1:0] s1_mid [3];
  logic [DW-1:0] s1_hi [3];
  logic [DW-1:0] s1_ctr, s2_ctr;
  logic [DW-1:0] s2_mx, s2_md, s2_mn;

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      s1_lo[r]  <= min2(min2(tap[r][0], tap[r][1]), tap[r][2]);
      s1_mid[r] <= med3(tap[r][0], tap[r][1], tap[r][2]);
      s1_hi[r]  <= max2(max2(tap[r][0], tap[r][1]), tap[r][2]);
    end
    s1_ctr <= w2_2;
    s2_mx  <= max2(max2(s1_lo[0], s1_lo[1]), s1_lo[2]);
    s2_md  <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
    s2_mn  <= min2(min2(s1_hi[0], s1_hi[1]), s1_hi[2]);
    s2_ctr <= s1_ctr;
  end

  logic          s1_valid, s2_valid;
  logic          s1_border, s2_border;
  logic          s1_last, s2_last;
  logic [CW-1:0] s1_col, s2_col;
  logic [RW-1:0] s1_row, s2_row;
  logic [DW-1:0] s3_pix;

  always_comb begin
    s3_pix = med3(s2_mx, s2_md, s2_mn);
    if (s2_border) begin
`ifdef BORDER_ZERO_EN
      s3_pix = '0;
`else
      s3_pix = s2_ctr;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_border  <= 1'b0;
      s1_last    <= 1'b0;
      s1_col     <= '0;
      s1_row     <= '0;
      s2_valid   <= 1'b0;
      s2_border  <= 1'b0;
      s2_last    <= 1'b0;
      s2_col     <= '0;
      s2_row     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      border     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      s1_valid   <= centre;
      s1_col     <= cen_col;
      s1_row     <= cen_row;
      s1_border  <= (cen_row == '0) || (cen_row == RW'(IMG_H - 1)) ||
                    (cen_col == '0) || (cen_col == CW'(IMG_W - 1));
      s1_last    <= (cen_row == RW'(IMG_H - 1)) && (cen_col == CW'(IMG_W - 1));
      s2_valid   <= s1_valid;
      s2_col     <= s1_col;
      s2_row     <= s1_row;
      s2_border  <= s1_border;
      s2_last    <= s1_last;
      dout       <= s3_pix;
      dout_valid <= s2_valid;
      out_col    <= s2_col;
      out_row    <= s2_row;
      border     <= s2_valid & s2_border;
      frame_done <= s2_valid & s2_last;
    end
  end

endmodule

// File: tb/tb_median_filter_3x3.sv
// Directed bench for median_filter_3x3 (IMG_W=8, IMG_H=6): table-driven sort vectors plus
// frame sequences checked against a scoreboard built from a clamped-window image model.
module tb_median_filter_3x3;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
`ifdef BORDER_ZERO_EN
  localparam bit ZERO_BRD = 1'b1;
`else
  localparam bit ZERO_BRD = 1'b0;
`endif

  typedef logic [8:0][7:0] taps_t;
  typedef struct { taps_t taps; logic [7:0] exp; } vec_t;
  typedef struct { logic [7:0] dout; int col; int row; logic brd; logic fd; int due; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] w1_1, w1_2, w1_3, w2_1, w2_2, w2_3, w3_1, w3_2, w3_3;
  logic [DW-1:0] dout;
  logic          dout_valid, border, frame_done;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;

  median_filter_3x3 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .w1_1(w1_1), .w1_2(w1_2), .w1_3(w1_3),
    .w2_1(w2_1), .w2_2(w2_2), .w2_3(w2_3),
    .w3_1(w3_1), .w3_2(w3_2), .w3_3(w3_3),
    .dout(dout), .dout_valid(dout_valid), .out_col(out_col), .out_row(out_row),
    .border(border), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   neg_cnt = 0;
  int   mdl_beats = 0, mdl_row = 0, mdl_col = 0, centres = 0;
  int   last_r = -1, last_c = -1;
  int   fr_valids = 0, fr_borders = 0, fd_total = 0;
  logic chk_255 = 1'b0, saw_255 = 1'b0;
  logic [7:0] img [H][W];
  exp_t exp_q [$];
  vec_t vecs [6];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic taps_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    taps_t t;
    t[0] = 8'(a0); t[1] = 8'(a1); t[2] = 8'(a2);
    t[3] = 8'(a3); t[4] = 8'(a4); t[5] = 8'(a5);
    t[6] = 8'(a6); t[7] = 8'(a7); t[8] = 8'(a8);
    return t;
  endfunction

  function automatic logic [7:0] med9(input taps_t t);
    logic [7:0] s [9];
    logic [7:0] tmp;
    for (int i = 0; i < 9; i++) s[i] = t[i];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp; end
    return s[4];
  endfunction

  // Window for centre (r,c) with edge clamping; newest column (c+1) comes first in each row.
  function automatic taps_t window(input int r, input int c);
    taps_t t;
    int k;
    k = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = 1; dc >= -1; dc--) begin
        int rr, cc;
        rr = r + dr; cc = c + dc;
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        t[k] = img[rr][cc];
        k++;
      end
    return t;
  endfunction

  task automatic drive(input logic v, input taps_t t, input logic ovr, input logic [7:0] ovr_val);
    exp_t e;
    logic brd;
    in_valid = v;
    w1_1 = t[0]; w1_2 = t[1]; w1_3 = t[2];
    w2_1 = t[3]; w2_2 = t[4]; w2_3 = t[5];
    w3_1 = t[6]; w3_2 = t[7]; w3_3 = t[8];
    @(posedge clk);
    if (v) begin
      if (mdl_beats >= W) begin
        brd    = (mdl_row == 0) || (mdl_row == H - 1) || (mdl_col == 0) || (mdl_col == W - 1);
        e.dout = ovr ? ovr_val : (brd ? (ZERO_BRD ? 8'd0 : t[4]) : med9(t));
        e.col  = mdl_col;
        e.row  = mdl_row;
        e.brd  = brd;
        e.fd   = (mdl_row == H - 1) && (mdl_col == W - 1);
        e.due  = neg_cnt + 3;
        exp_q.push_back(e);
        last_r = mdl_row;
        last_c = mdl_col;
        if (mdl_col == W - 1) begin
          mdl_col = 0;
          mdl_row = (mdl_row == H - 1) ? 0 : mdl_row + 1;
        end else begin
          mdl_col++;
        end
        centres++;
      end
      mdl_beats++;
    end
    #1;
  endtask

  task automatic img_beat(input logic v);
    taps_t t;
    for (int i = 0; i < 9; i++) t[i] = 8'($urandom);
    if (v && mdl_beats >= W) t = window(mdl_row, mdl_col);
    drive(v, t, 1'b0, 8'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_out_col"}, out_col, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_border"}, border, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'(r * W + c + 1);
  endtask

  // Scoreboard: every cycle the valid flag must match the expected 3-cycle-shifted beat pattern.
  always @(negedge clk) begin
    logic due;
    neg_cnt++;
    if (!rst) begin
      fr_valids  = 0;
      fr_borders = 0;
    end else begin
      due = (exp_q.size() > 0) && (exp_q[0].due == neg_cnt);
      check("dout_valid", dout_valid, due);
      check("frame_done_gated", frame_done & ~dout_valid, 0);
      if (dout_valid && due) begin
        check("dout", dout, exp_q[0].dout);
        check("out_col", out_col, exp_q[0].col);
        check("out_row", out_row, exp_q[0].row);
        check("border", border, exp_q[0].brd);
        check("frame_done", frame_done, exp_q[0].fd);
      end
      if (exp_q.size() > 0 && exp_q[0].due <= neg_cnt) void'(exp_q.pop_front());
      if (dout_valid) begin
        fr_valids++;
        if (border) fr_borders++;
        if (chk_255 && dout == 8'd255) saw_255 = 1'b1;
        if (frame_done) begin
          check("valids_per_frame", fr_valids, W * H);
          check("borders_per_frame", fr_borders, 2 * W + 2 * H - 4);
          fd_total++;
          fr_valids  = 0;
          fr_borders = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ti;
    vecs[0] = '{mk(9, 1, 8, 2, 7, 3, 6, 4, 5), 8'd5};
    vecs[1] = '{mk(200, 200, 200, 0, 0, 0, 255, 255, 255), 8'd200};
    vecs[2] = '{mk(3, 3, 3, 3, 3, 3, 3, 3, 3), 8'd3};
    vecs[3] = '{mk(0, 255, 0, 255, 0, 255, 0, 255, 0), 8'd0};
    vecs[4] = '{mk(255, 254, 253, 252, 251, 250, 249, 248, 247), 8'd251};
    vecs[5] = '{mk(1, 1, 2, 2, 2, 9, 9, 9, 9), 8'd2};

    {w1_1, w1_2, w1_3, w2_1, w2_2, w2_3, w3_1, w3_2, w3_3} = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;

    // Frame 1: ramp, covers warm-up and first centre (0,0).
    fill_ramp();
    while (centres < W * H) img_beat(1'b1);

    // Frame 2: flat 10 with a single 255 impulse at (3,4).
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'd10;
    img[3][4] = 8'd255;
    chk_255 = 1'b1;
    while (centres < 2 * W * H) img_beat(1'b1);

    // Frame 3: table vectors at interior centres, ramp elsewhere.
    fill_ramp();
    ti = 0;
    while (centres < 3 * W * H) begin
      if (ti < 6 && mdl_row > 0 && mdl_row < H - 1 && mdl_col > 0 && mdl_col < W - 1) begin
        drive(1'b1, vecs[ti].taps, 1'b1, vecs[ti].exp);
        ti++;
      end else begin
        img_beat(1'b1);
      end
    end
    chk_255 = 1'b0;

    // Frame 4: constant 77.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'd77;
    while (centres < 4 * W * H) img_beat(1'b1);

    // Frames 5-6: in_valid dropped every third cycle.
    fill_ramp();
    for (int k = 0; centres < 6 * W * H; k++) img_beat((k % 3) != 2);

    // Mid-frame reset once centre (2,3) has been accepted.
    for (int n = 0; n < 100 && !(last_r == 2 && last_c == 3); n++) img_beat(1'b1);
    check("reached_centre_2_3", last_r * W + last_c, 2 * W + 3);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("midreset");
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("midreset_hold");
    rst = 1'b1;
    mdl_beats = 0;
    mdl_row   = 0;
    mdl_col   = 0;
    repeat (W + 1 + 6) img_beat(1'b1);
    repeat (6) img_beat(1'b0);

    check("frames_done", fd_total, 6);
    check("queue_drained", exp_q.size(), 0);
    check("no_impulse_output", saw_255, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
